// File: rtl/prga_fifo_counted.sv
// prga_fifo_counted
//   Synchronous FIFO with a configurable depth, an occupancy count and
//   programmable almost-full and almost-empty flags. It also provides a
//   synchronous flush and sticky overflow/underflow error flags. The read
//   port is either registered (LOOKAHEAD=0) or first-word-fall-through
//   (LOOKAHEAD=1).
//
// Handshake: a write is accepted when wr=1 and full=0. A read is accepted
//   when rd=1 and empty=0. Both decisions use the flags as they stand before
//   the clock edge. A refused request is dropped and sets its sticky error
//   flag. Nothing is stalled or retried.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   flush                synchronous clear of contents and error flags
//   wr, din              write request and data
//   rd                   read request (pop of the current head when LOOKAHEAD=1)
//   dout                 read data
//   full, almost_full    count == DEPTH, count >= DEPTH - AF_MARGIN
//   empty, almost_empty  count == 0,     count <= AE_MARGIN
//   count                occupancy, 0..DEPTH
//   overflow, underflow  sticky error flags
module prga_fifo_counted #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter int LOOKAHEAD  = 0,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  output logic                  almost_empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Every flag is decoded from the registered count. No path exists from
  // wr or rd to a flag.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // In lookahead mode the head entry is shown directly. When the FIFO is
  // empty this is a stale entry, which is still a stable value.
  assign dout = (LOOKAHEAD != 0) ? mem_q[rd_ptr_q] : dout_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      // Flush takes priority: requests in this cycle are ignored and raise no error.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        dout_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      if (wr & full)  overflow_d  = 1'b1;
      if (rd & empty) underflow_d = 1'b1;
    end
  end

  // The storage array is cleared on reset as well. This makes the lookahead
  // output read 0 after reset, the same as the registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_prga_fifo_counted.sv
// tb_prga_fifo_counted
//   Two instances, one with LOOKAHEAD=0 and one with LOOKAHEAD=1, are driven
//   by the same inputs. A queue-based reference model tracks the expected
//   contents, flags and registered read data. Directed scenarios are
//   followed by a randomized phase.
module tb_prga_fifo_counted;

  localparam int DW    = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] din = '0;

  logic          full0, afull0, empty0, aempty0, ovf0, unf0;
  logic [DW-1:0] dout0;
  logic [DL2:0]  count0;
  logic          full1, afull1, empty1, aempty1, ovf1, unf1;
  logic [DW-1:0] dout1;
  logic [DL2:0]  count1;

  prga_fifo_counted #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(0),
                      .AF_MARGIN(1), .AE_MARGIN(1)) u_la0 (
    .clk(clk), .rst(rst), .flush(flush),
    .full(full0), .almost_full(afull0), .wr(wr), .din(din),
    .empty(empty0), .almost_empty(aempty0), .rd(rd), .dout(dout0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  prga_fifo_counted #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(1),
                      .AF_MARGIN(1), .AE_MARGIN(1)) u_la1 (
    .clk(clk), .rst(rst), .flush(flush),
    .full(full1), .almost_full(afull1), .wr(wr), .din(din),
    .empty(empty1), .almost_empty(aempty1), .rd(rd), .dout(dout1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;   // expected registered dout (LOOKAHEAD=0)
  logic          m_ovf;
  logic          m_unf;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    logic was_full, was_empty;
    if (f) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) m_dout = exp_q.pop_front();
      if (w && !was_full)  exp_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    int n;
    n = exp_q.size();
    check_eq("count_la0",  32'(count0),  32'(n));
    check_eq("count_la1",  32'(count1),  32'(n));
    check_eq("empty_la0",  32'(empty0),  32'(n == 0));
    check_eq("empty_la1",  32'(empty1),  32'(n == 0));
    check_eq("full_la0",   32'(full0),   32'(n == DEPTH));
    check_eq("full_la1",   32'(full1),   32'(n == DEPTH));
    check_eq("afull_la0",  32'(afull0),  32'(n >= DEPTH - 1));
    check_eq("afull_la1",  32'(afull1),  32'(n >= DEPTH - 1));
    check_eq("aempty_la0", 32'(aempty0), 32'(n <= 1));
    check_eq("aempty_la1", 32'(aempty1), 32'(n <= 1));
    check_eq("ovf_la0",    32'(ovf0),    32'(m_ovf));
    check_eq("ovf_la1",    32'(ovf1),    32'(m_ovf));
    check_eq("unf_la0",    32'(unf0),    32'(m_unf));
    check_eq("unf_la1",    32'(unf1),    32'(m_unf));
    check_eq("dout_la0",   32'(dout0),   32'(m_dout));
    if (n > 0) check_eq("dout_la1", 32'(dout1), 32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    @(negedge clk);
    wr = w; din = d; rd = r; flush = f;
    @(posedge clk);
    model_edge(w, d, r, f);
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    compare_all();                         // state while reset is asserted
    @(negedge clk);
    rst = 1'b0;

    // Test 1: fill, then a write while full is dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check_eq("t1_overflow", 32'(ovf0), 32'd1);
    check_eq("t1_count",    32'(count0), 32'd4);

    // Test 2: drain in order, then a read while empty.
    for (int i = 1; i <= 4; i++) begin
      check_eq("t2_la1_head", 32'(dout1), 32'(i * 8'h11));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("t2_la0_data", 32'(dout0), 32'(i * 8'h11));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t2_underflow", 32'(unf0), 32'd1);
    check_eq("t2_dout_hold", 32'(dout0), 32'h44);

    // Test 3: ten rounds of three writes and three reads across the pointer wrap.
    step(1'b0, 8'h00, 1'b0, 1'b1);         // clear the sticky flags first
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int k = 0; k < 3; k++) step(1'b1, 8'(rnd * 3 + k), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("t3_round_last", 32'(dout0), 32'(rnd * 3 + 2));
    end
    check_eq("t3_no_ovf", 32'(ovf0), 32'd0);

    // Test 4: simultaneous requests while full, then while empty.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check_eq("t4_full_count", 32'(count0), 32'd3);
    check_eq("t4_full_ovf",   32'(ovf0),   32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    check_eq("t4_empty_count", 32'(count0), 32'd1);
    check_eq("t4_empty_unf",   32'(unf0),   32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t4_read_bb", 32'(dout0), 32'hBB);

    // Test 5: flush with a write in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    check_eq("t5_count", 32'(count0), 32'd0);
    check_eq("t5_ovf",   32'(ovf0),   32'd0);

    // Test 6: asynchronous reset between edges.
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_count", 32'(count0), 32'd0);
    check_eq("t6_empty", 32'(empty1), 32'd1);
    check_eq("t6_dout0", 32'(dout0),  32'd0);
    check_eq("t6_dout1", 32'(dout1),  32'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check_eq("t6_la1_head", 32'(dout1), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t6_la0_read", 32'(dout0), 32'h5A);

    // Randomized phase.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    end

    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
